// File: rtl/instaweb_pkg.sv
// Shared definitions for the instaweb relay TX scheduler: FSM encoding,
// default channel count and owner-field indexing.
package instaweb_pkg;

  localparam int unsigned DEF_NUM_CH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARB   = 2'd1,
    ST_GRANT = 2'd2,
    ST_DRAIN = 2'd3
  } sched_state_e;

  // LSB of channel ch's owner-id field in the flat ch_owner vector
  function automatic int unsigned owner_lsb(input int unsigned ch, input int unsigned req_w);
    return ch * req_w;
  endfunction

endpackage

// File: rtl/instaweb_rr_arbiter.sv
// Rotating-priority select: first eligible lane at or after rr_ptr, wrapping.
module instaweb_rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned REQ_W   = 2
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [REQ_W-1:0]   rr_ptr,
  output logic               hit,
  output logic [REQ_W-1:0]   id
);

  logic [REQ_W-1:0] idx;

  always_comb begin
    hit = 1'b0;
    id  = '0;
    idx = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = REQ_W'((32'(rr_ptr) + k) % NUM_REQ);
      if (!hit && eligible[idx]) begin
        hit = 1'b1;
        id  = idx;
      end
    end
  end

endmodule

// File: rtl/instaweb_tx_scheduler.sv
// Shares the relay's optical TX channels between relay lanes: round-robin grants
// of whole channel masks, each channel then held for BURST_LEN cycles.
module instaweb_tx_scheduler
  import instaweb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned NUM_CH    = DEF_NUM_CH,
  parameter int unsigned BURST_LEN = 16,
  parameter int unsigned REQ_W     = $clog2(NUM_REQ),
  parameter int unsigned CNT_W     = $clog2(BURST_LEN + 1)
) (
  input  logic                      clk_2g,
  input  logic                      rst,
  input  logic                      sched_en,
  input  logic [NUM_CH-1:0]         ch_enable,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*NUM_CH-1:0] req_mask,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      grant_valid,
  output logic [REQ_W-1:0]          grant_id,
  output logic [NUM_CH-1:0]         grant_mask,
  output logic [NUM_CH-1:0]         ch_busy,
  output logic [NUM_CH*REQ_W-1:0]   ch_owner,
  output logic                      err_empty_mask,
  output logic                      drain_done
);

  sched_state_e state, state_nxt;

  logic [REQ_W-1:0]   rr_ptr;
  logic [REQ_W-1:0]   pend_id;
  logic [NUM_REQ-1:0] eligible;
  logic               arb_hit;
  logic [REQ_W-1:0]   arb_id;
  logic [NUM_CH-1:0]  sel_mask;
  logic               take;

  logic [NUM_REQ-1:0] req_ready_d;
  logic               grant_valid_d;
  logic [REQ_W-1:0]   grant_id_d;
  logic [NUM_CH-1:0]  grant_mask_d;
  logic               err_d;

  logic [CNT_W-1:0]          cnt     [NUM_CH];
  logic [CNT_W-1:0]          cnt_nxt [NUM_CH];
  logic [NUM_CH*REQ_W-1:0]   owner_nxt;

  // A lane is eligible only if none of its channels is owned or disabled
  always_comb begin
    eligible = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      eligible[i] = req_valid[i] &&
                    ((req_mask[i*NUM_CH +: NUM_CH] & (ch_busy | ~ch_enable)) == '0);
    end
  end

  instaweb_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .REQ_W   (REQ_W)
  ) u_arb (
    .eligible (eligible),
    .rr_ptr   (rr_ptr),
    .hit      (arb_hit),
    .id       (arb_id)
  );

  always_comb begin
    sel_mask = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (arb_id == REQ_W'(i)) sel_mask = req_mask[i*NUM_CH +: NUM_CH];
    end
  end

  assign take = (state == ST_ARB) && sched_en && (|req_valid) && arb_hit;

  // FSM state register
  always_ff @(posedge clk_2g or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // FSM next state
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (sched_en && (|req_valid)) state_nxt = ST_ARB;
      ST_ARB: begin
        if (!sched_en)        state_nxt = ST_DRAIN;
        else if (!(|req_valid)) state_nxt = ST_IDLE;
        else if (arb_hit)     state_nxt = ST_GRANT;
      end
      ST_GRANT: state_nxt = sched_en ? ST_ARB : ST_DRAIN;
      ST_DRAIN: begin
        if (sched_en)          state_nxt = ST_ARB;
        else if (!(|ch_busy))  state_nxt = ST_IDLE;
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: next values of the grant handshake, registered below
  always_comb begin
    req_ready_d   = '0;
    grant_valid_d = 1'b0;
    grant_id_d    = '0;
    grant_mask_d  = '0;
    err_d         = 1'b0;
    if (take) begin
      req_ready_d[arb_id] = 1'b1;
      if (sel_mask != '0) begin
        grant_valid_d = 1'b1;
        grant_id_d    = arb_id;
        grant_mask_d  = sel_mask;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_2g or posedge rst) begin
    if (rst) begin
      req_ready      <= '0;
      grant_valid    <= 1'b0;
      grant_id       <= '0;
      grant_mask     <= '0;
      err_empty_mask <= 1'b0;
      pend_id        <= '0;
      rr_ptr         <= '0;
    end else begin
      req_ready      <= req_ready_d;
      grant_valid    <= grant_valid_d;
      grant_id       <= grant_id_d;
      grant_mask     <= grant_mask_d;
      err_empty_mask <= err_d;
      if (take) pend_id <= arb_id;
      // Pointer moves past the served lane, empty-mask acknowledgements included
      if (state == ST_GRANT)
        rr_ptr <= (pend_id == REQ_W'(NUM_REQ - 1)) ? '0 : REQ_W'(pend_id + 1'b1);
    end
  end

  // Hold counters: load on the grant pulse, count down to zero, release ownership at expiry
  always_comb begin
    owner_nxt = ch_owner;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      cnt_nxt[c] = cnt[c];
      if (grant_valid && grant_mask[c]) begin
        cnt_nxt[c] = CNT_W'(BURST_LEN);
        owner_nxt[owner_lsb(c, REQ_W) +: REQ_W] = grant_id;
      end else if (cnt[c] != '0) begin
        cnt_nxt[c] = cnt[c] - 1'b1;
        if (cnt[c] == CNT_W'(1)) owner_nxt[owner_lsb(c, REQ_W) +: REQ_W] = '0;
      end
    end
  end

  always_ff @(posedge clk_2g or posedge rst) begin
    if (rst) begin
      for (int unsigned c = 0; c < NUM_CH; c++) cnt[c] <= '0;
      ch_busy  <= '0;
      ch_owner <= '0;
    end else begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        cnt[c]     <= cnt_nxt[c];
        ch_busy[c] <= (cnt_nxt[c] != '0);
      end
      ch_owner <= owner_nxt;
    end
  end

  assign drain_done = ~sched_en & ~(|ch_busy);

endmodule

// File: tb/tb_instaweb_tx_scheduler.sv
// Scoreboard bench for instaweb_tx_scheduler: directed lane requests, expected
// acknowledgements queued up front and checked by an independent monitor.
module tb_instaweb_tx_scheduler;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] mask;
    logic       err;
  } exp_t;

  logic        clk_2g = 1'b0;
  logic        rst = 1'b1;
  logic        sched_en = 1'b0;
  logic [7:0]  ch_enable = 8'hFF;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_mask = '0;
  logic [3:0]  req_ready;
  logic        grant_valid;
  logic [1:0]  grant_id;
  logic [7:0]  grant_mask;
  logic [7:0]  ch_busy;
  logic [15:0] ch_owner;
  logic        err_empty_mask;
  logic        drain_done;

  int nvec = 0;
  int nfail = 0;
  int cyc = 0;
  int ngr = 0;
  int issued [4] = '{default: 0};
  int taken  [4] = '{default: 0};
  int pcyc   [4] = '{default: 0};
  int gcyc   [4] = '{default: 0};
  logic [7:0] mq [4][16];
  exp_t exp_q[$];
  logic [3:0] vprev = '0;

  instaweb_tx_scheduler #(
    .NUM_REQ   (4),
    .NUM_CH    (8),
    .BURST_LEN (16)
  ) dut (
    .clk_2g         (clk_2g),
    .rst            (rst),
    .sched_en       (sched_en),
    .ch_enable      (ch_enable),
    .req_valid      (req_valid),
    .req_mask       (req_mask),
    .req_ready      (req_ready),
    .grant_valid    (grant_valid),
    .grant_id       (grant_id),
    .grant_mask     (grant_mask),
    .ch_busy        (ch_busy),
    .ch_owner       (ch_owner),
    .err_empty_mask (err_empty_mask),
    .drain_done     (drain_done)
  );

  always #5 clk_2g = ~clk_2g;

  always @(posedge clk_2g) cyc <= cyc + 1;

  // Lane drivers: hold each queued request until its req_ready, then present the next
  always @(negedge clk_2g) begin
    for (int i = 0; i < 4; i++) begin
      if (rst) begin
        req_valid[i] = 1'b0;
        taken[i] = issued[i];
      end else begin
        if (req_valid[i] && req_ready[i]) begin
          req_valid[i] = 1'b0;
          taken[i] = taken[i] + 1;
        end
        if (!req_valid[i] && taken[i] < issued[i]) begin
          req_valid[i] = 1'b1;
          req_mask[i*8 +: 8] = mq[i][taken[i] & 15];
          pcyc[i] = cyc;
        end
      end
    end
  end

  // Monitor: every acknowledgement is matched against the head of the expected queue
  always @(negedge clk_2g) begin
    exp_t e;
    logic [3:0] rdy;
    if (!rst && ((|req_ready) || grant_valid || err_empty_mask)) begin
      nvec = nvec + 1;
      if (exp_q.size() == 0) begin
        nfail = nfail + 1;
        $display("FAIL unexpected_ack: ready=%b id=%0d mask=%h err=%b, none expected",
                 req_ready, grant_id, grant_mask, err_empty_mask);
      end else begin
        e = exp_q.pop_front();
        rdy = 4'b0001 << e.id;
        if (req_ready !== rdy || grant_valid !== !e.err || err_empty_mask !== e.err ||
            (!e.err && (grant_id !== e.id || grant_mask !== e.mask))) begin
          nfail = nfail + 1;
          $display("FAIL ack: got ready=%b gv=%b id=%0d mask=%h err=%b, expected ready=%b gv=%b id=%0d mask=%h err=%b",
                   req_ready, grant_valid, grant_id, grant_mask, err_empty_mask,
                   rdy, !e.err, e.id, e.mask, e.err);
        end
      end
      for (int i = 0; i < 4; i++) if (req_ready[i]) gcyc[i] = cyc;
      ngr = ngr + 1;
    end
  end

  // Lanes must not withdraw a request before it is consumed
  always @(posedge clk_2g) begin
    if (rst) begin
      vprev <= '0;
    end else begin
      for (int i = 0; i < 4; i++)
        assert (!(vprev[i] && !req_valid[i] && !req_ready[i]))
          else $error("protocol: lane %0d dropped req_valid before req_ready", i);
      vprev <= req_valid;
    end
  end

  task automatic step();
    @(posedge clk_2g);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec = nvec + 1;
    if (act !== exp) begin
      nfail = nfail + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic issue(input int lane, input logic [7:0] m);
    mq[lane][issued[lane] & 15] = m;
    issued[lane] = issued[lane] + 1;
  endtask

  task automatic push(input int id, input logic [7:0] m, input logic err);
    exp_t e;
    e.id = 2'(id);
    e.mask = m;
    e.err = err;
    exp_q.push_back(e);
  endtask

  task automatic wait_acks(input string name, input int target, input int max_cyc);
    int k = 0;
    while (ngr < target && k < max_cyc) begin
      step();
      k++;
    end
    if (ngr < target) begin
      nvec = nvec + 1;
      nfail = nfail + 1;
      $display("FAIL %s: timeout, got %0d acks expected %0d", name, ngr, target);
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    int base;
    int cnt;
    int t;

    // Reset state
    rst = 1'b1; sched_en = 1'b0; ch_enable = 8'hFF;
    step(); step();
    rst = 1'b0;
    step();
    chk("reset_drain_done", 64'(drain_done), 64'd1);
    chk("reset_outputs", {req_ready, grant_valid, grant_id, grant_mask, ch_busy, ch_owner, err_empty_mask}, 64'd0);

    // 1: single lane, two-cycle latency, 16-cycle hold
    sched_en = 1'b1;
    base = ngr;
    issue(0, 8'h03); push(0, 8'h03, 1'b0);
    wait_acks("t1_ack", base + 1, 20);
    chk("t1_latency", 64'(gcyc[0] - pcyc[0]), 64'd2);
    chk("t1_busy", 64'(ch_busy), 64'h03);
    chk("t1_owner", 64'(ch_owner), 64'h0);
    cnt = 0;
    for (int j = 0; j < 20; j++) begin
      if (ch_busy == 8'h03) cnt++;
      step();
    end
    chk("t1_busy_cycles", 64'(cnt), 64'd16);
    chk("t1_busy_released", 64'(ch_busy), 64'h0);

    // 2: fairness over disjoint masks, two rounds
    do_reset();
    base = ngr;
    for (int r = 0; r < 2; r++) begin
      issue(0, 8'h01); issue(1, 8'h02); issue(2, 8'h04); issue(3, 8'h08);
    end
    for (int r = 0; r < 2; r++) begin
      push(0, 8'h01, 1'b0); push(1, 8'h02, 1'b0); push(2, 8'h04, 1'b0); push(3, 8'h08, 1'b0);
    end
    wait_acks("t2_round1", base + 4, 30);
    chk("t2_spacing01", 64'(gcyc[1] - gcyc[0]), 64'd2);
    chk("t2_spacing12", 64'(gcyc[2] - gcyc[1]), 64'd2);
    chk("t2_spacing23", 64'(gcyc[3] - gcyc[2]), 64'd2);
    chk("t2_busy_round1", 64'(ch_busy), 64'h0F);
    wait_acks("t2_round2", base + 8, 100);

    // 3: conflicting lane waits for expiry while a disjoint lane passes it
    do_reset();
    base = ngr;
    issue(0, 8'h01); issue(1, 8'h03); issue(2, 8'h04);
    push(0, 8'h01, 1'b0); push(2, 8'h04, 1'b0); push(1, 8'h03, 1'b0);
    wait_acks("t3_lane2", base + 2, 20);
    chk("t3_busy_mid", 64'(ch_busy), 64'h05);
    chk("t3_owner_mid", 64'(ch_owner), 64'h0020);
    wait_acks("t3_lane1", base + 3, 40);
    chk("t3_conflict_wait", 64'(gcyc[1] - gcyc[0]), 64'd18);
    chk("t3_busy_end", 64'(ch_busy), 64'h03);
    chk("t3_owner_end", 64'(ch_owner), 64'h0005);

    // 4: disabled channel is never granted; empty mask is acknowledged as an error
    do_reset();
    ch_enable = 8'hFE;
    base = ngr;
    issue(0, 8'h01); issue(1, 8'h00);
    push(1, 8'h00, 1'b1);
    wait_acks("t4_empty", base + 1, 20);
    chk("t4_empty_latency", 64'(gcyc[1] - pcyc[1]), 64'd2);
    chk("t4_no_busy", 64'(ch_busy), 64'h0);
    repeat (40) step();
    chk("t4_disabled_never", 64'(ngr - base), 64'd1);
    chk("t4_no_busy_late", 64'(ch_busy), 64'h0);
    ch_enable = 8'hFF;

    // 5: drain mid-burst, then resume from idle
    do_reset();
    base = ngr;
    issue(0, 8'h0F); push(0, 8'h0F, 1'b0);
    wait_acks("t5_ack", base + 1, 20);
    sched_en = 1'b0;
    issue(1, 8'h10);
    chk("t5_drain_busy", 64'(drain_done), 64'd0);
    repeat (15) step();
    chk("t5_drain_last_busy", {ch_busy, 7'd0, drain_done}, {8'h0F, 8'h00});
    step();
    chk("t5_drain_done", {ch_busy, 7'd0, drain_done}, {8'h00, 8'h01});
    chk("t5_no_grant", 64'(ngr - base), 64'd1);
    repeat (3) step();
    push(1, 8'h10, 1'b0);
    sched_en = 1'b1;
    t = cyc;
    wait_acks("t5_resume", base + 2, 20);
    chk("t5_resume_latency", 64'(gcyc[1] - t), 64'd2);

    // 6: asynchronous reset with every channel owned
    do_reset();
    base = ngr;
    issue(0, 8'h0F); issue(1, 8'h30); issue(2, 8'hC0);
    push(0, 8'h0F, 1'b0); push(1, 8'h30, 1'b0); push(2, 8'hC0, 1'b0);
    wait_acks("t6_fill", base + 3, 30);
    chk("t6_all_busy", 64'(ch_busy), 64'hFF);
    rst = 1'b1;
    #1;
    chk("t6_rst_busy_owner", {ch_busy, ch_owner}, 64'h0);
    chk("t6_rst_ctrl", {req_ready, grant_valid, grant_id, grant_mask, err_empty_mask, drain_done}, 64'h0);
    step(); step();
    rst = 1'b0;
    step();
    issue(3, 8'h81); push(3, 8'h81, 1'b0);
    wait_acks("t6_after_rst", base + 4, 20);
    chk("t6_latency", 64'(gcyc[3] - pcyc[3]), 64'd2);
    chk("t6_busy", 64'(ch_busy), 64'h81);
    chk("t6_owner", 64'(ch_owner), 64'hC003);

    step();
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
